// File: rtl/prime_sieve_pkg.sv
// Shared types and sizing for the prime sieve result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prime_sieve_pkg;

    // Highest index of the default composite-flag vector
    localparam int N_MAX_DEFAULT = 100;

    // Bits needed to hold any index 0..n_max
    function automatic int idx_width(input int n_max);
        return $clog2(n_max + 1);
    endfunction

    localparam int IDX_W_DEFAULT = idx_width(N_MAX_DEFAULT);

    // Reader FSM states
    typedef enum logic [1:0] {
        PSR_IDLE,
        PSR_SCAN,
        PSR_EMIT,
        PSR_DONE
    } psr_state_t;

    // Composite-flag vector at the default size (bit i = 1 -> i is not prime)
    typedef logic [N_MAX_DEFAULT:0] psr_flags_t;

endpackage

// File: rtl/prime_remaining_detect.sv
// Flags whether any prime (zero flag bit) lies strictly above the current index.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module prime_remaining_detect
    import prime_sieve_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEFAULT,
    parameter int IDX_W = idx_width(N_MAX)
) (
    input  logic [N_MAX:0]   snapshot,
    input  logic [IDX_W-1:0] out_prime,
    output logic             any_above
);

    // OR of the inverted flags at indices above out_prime
    always_comb begin
        any_above = 1'b0;
        for (int i = 0; i <= N_MAX; i++) begin
            if (i > int'(out_prime)) begin
                any_above = any_above | ~snapshot[i];
            end
        end
    end

endmodule

// File: rtl/prime_stream_reader.sv
// Snapshots the sieve's composite flags and streams prime indices ascending (optional PRIME_STREAM_COUNT_EN adds prime_count).
// Latency: first prime (2) valid 3 edges after capture; next prime p' valid (p'-p) edges after transfer of p.
// Backpressure: out_valid/out_prime/out_last held stable until out_ready; scanning pauses while a prime waits.
module prime_stream_reader
    import prime_sieve_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEFAULT,
    parameter int IDX_W = idx_width(N_MAX)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sieve_done,
    input  logic [N_MAX:0]   composite_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_prime,
    output logic             out_last,
    output logic             all_sent,
    output logic             busy
`ifdef PRIME_STREAM_COUNT_EN
    ,
    output logic [IDX_W-1:0] prime_count
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MAX);

    psr_state_t       state_q;
    logic [N_MAX:0]   snapshot_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic [IDX_W-1:0] out_prime_q;
    logic             out_valid_q;
    logic             all_sent_q;
    logic             busy_q;

    logic             any_above;
    logic             scan_flag;
    logic             scan_at_end;
    logic             xfer;
    logic             last_w;
    logic [IDX_W-1:0] scan_idx_d;
    logic [IDX_W-1:0] resume_idx_d;

    // Any prime left above the one currently offered?
    prime_remaining_detect #(
        .N_MAX (N_MAX),
        .IDX_W (IDX_W)
    ) u_remaining (
        .snapshot  (snapshot_q),
        .out_prime (out_prime_q),
        .any_above (any_above)
    );

    assign scan_flag    = snapshot_q[scan_idx_q];
    assign scan_at_end  = (scan_idx_q == IDX_LAST);
    assign xfer         = out_valid_q & out_ready;
    assign last_w       = out_valid_q & ~any_above;
    // Only consumed when out_prime_q < N_MAX, so the increment never wraps in use
    assign scan_idx_d   = scan_idx_q + IDX_W'(1);
    assign resume_idx_d = out_prime_q + IDX_W'(1);

    // Reader FSM: capture, scan one index per cycle, offer primes, park in DONE until done drops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PSR_IDLE;
            snapshot_q  <= '1;
            scan_idx_q  <= '0;
            out_prime_q <= '0;
            out_valid_q <= 1'b0;
            all_sent_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                PSR_IDLE: begin
                    if (sieve_done) begin
                        snapshot_q <= composite_flags;
                        scan_idx_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= PSR_SCAN;
                    end
                end
                PSR_SCAN: begin
                    if (!scan_flag) begin
                        out_prime_q <= scan_idx_q;
                        out_valid_q <= 1'b1;
                        state_q     <= PSR_EMIT;
                    end else if (scan_at_end) begin
                        busy_q     <= 1'b0;
                        all_sent_q <= 1'b1;
                        state_q    <= PSR_DONE;
                    end else begin
                        scan_idx_q <= scan_idx_d;
                    end
                end
                PSR_EMIT: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        if ((out_prime_q == IDX_LAST) || last_w) begin
                            busy_q     <= 1'b0;
                            all_sent_q <= 1'b1;
                            state_q    <= PSR_DONE;
                        end else begin
                            scan_idx_q <= resume_idx_d;
                            state_q    <= PSR_SCAN;
                        end
                    end
                end
                PSR_DONE: begin
                    // Holding sieve_done high keeps the old result; a fresh rise is needed to re-capture
                    if (!sieve_done) begin
                        all_sent_q <= 1'b0;
                        state_q    <= PSR_IDLE;
                    end
                end
                default: begin
                    state_q <= PSR_IDLE;
                end
            endcase
        end
    end

`ifdef PRIME_STREAM_COUNT_EN
    logic [IDX_W-1:0] count_q;

    // Accepted-transfer counter, cleared on each new capture
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if ((state_q == PSR_IDLE) && sieve_done) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + IDX_W'(1);
        end
    end

    assign prime_count = count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_prime = out_prime_q;
    assign out_last  = last_w;
    assign all_sent  = all_sent_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prime_stream_reader.sv
// Bench for prime_stream_reader: a 100-index instance and a 7-index instance on one clock.
// Latency: checks capture-to-first-prime, all-ones scan length and DONE timing.
// Backpressure: stalls the sink and checks the offered prime holds steady.
module tb_prime_stream_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 100-index instance
    logic         a_done;
    logic [100:0] a_flags;
    logic         a_ready;
    logic         a_valid;
    logic [6:0]   a_prime;
    logic         a_last;
    logic         a_all;
    logic         a_busy;
`ifdef PRIME_STREAM_COUNT_EN
    logic [6:0]   a_cnt;
`endif

    // 7-index instance
    logic       b_done;
    logic [7:0] b_flags;
    logic       b_ready;
    logic       b_valid;
    logic [2:0] b_prime;
    logic       b_last;
    logic       b_all;
    logic       b_busy;
`ifdef PRIME_STREAM_COUNT_EN
    logic [2:0] b_cnt;
`endif

    prime_stream_reader #(.N_MAX(100), .IDX_W(7)) u_dut_a (
        .clock           (clk),
        .reset           (reset),
        .sieve_done      (a_done),
        .composite_flags (a_flags),
        .out_valid       (a_valid),
        .out_ready       (a_ready),
        .out_prime       (a_prime),
        .out_last        (a_last),
        .all_sent        (a_all),
        .busy            (a_busy)
`ifdef PRIME_STREAM_COUNT_EN
        ,
        .prime_count     (a_cnt)
`endif
    );

    prime_stream_reader #(.N_MAX(7), .IDX_W(3)) u_dut_b (
        .clock           (clk),
        .reset           (reset),
        .sieve_done      (b_done),
        .composite_flags (b_flags),
        .out_valid       (b_valid),
        .out_ready       (b_ready),
        .out_prime       (b_prime),
        .out_last        (b_last),
        .all_sent        (b_all),
        .busy            (b_busy)
`ifdef PRIME_STREAM_COUNT_EN
        ,
        .prime_count     (b_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];
    int n_xfer_a = 0;
    bit a_vseen = 1'b0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Flags with only the primes in [lo,hi] cleared; optionally queue them as expected output
    task automatic build_flags(input int lo, input int hi, input bit push, output logic [100:0] f);
        f = '1;
        for (int i = 0; i <= 100; i++) begin
            if (is_prime(i) && i >= lo && i <= hi) begin
                f[i] = 1'b0;
                if (push) qa.push_back(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        for (int n = 0; n < 400; n++) begin
            if (!a_busy && !a_all) break;
            tick();
        end
        chk_eq("a_idle_reached", int'(a_busy | a_all), 0);
    endtask

    task automatic wait_valid_a();
        for (int n = 0; n < 400; n++) begin
            if (a_valid) break;
            tick();
        end
        chk_eq("a_valid_reached", int'(a_valid), 1);
    endtask

    task automatic wait_drain_a();
        for (int n = 0; n < 2000; n++) begin
            if (qa.size() == 0) break;
            tick();
        end
        chk_eq("a_queue_drained", qa.size(), 0);
    endtask

    // Scoreboard for instance A: every accepted prime must match the head of the queue
    always @(negedge clk) begin
        int exp;
        if (!reset && a_valid) a_vseen = 1'b1;
        if (!reset && a_valid && a_ready) begin
            exp = (qa.size() != 0) ? qa.pop_front() : 999;
            chk_eq("a_prime", int'(a_prime), exp);
            chk_eq("a_last", int'(a_last), int'(qa.size() == 0));
            n_xfer_a++;
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        int exp;
        if (!reset && b_valid && b_ready) begin
            exp = (qb.size() != 0) ? qb.pop_front() : 999;
            chk_eq("b_prime", int'(b_prime), exp);
            chk_eq("b_last", int'(b_last), int'(qb.size() == 0));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [100:0] f;
        int base;
        int n;

        reset   = 1'b1;
        a_done  = 1'b0;
        a_flags = '0;
        a_ready = 1'b1;
        b_done  = 1'b0;
        b_flags = '0;
        b_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk_eq("rst_a_valid", int'(a_valid), 0);
        chk_eq("rst_a_busy", int'(a_busy), 0);
        chk_eq("rst_a_all", int'(a_all), 0);
        chk_eq("rst_a_prime", int'(a_prime), 0);
        chk_eq("rst_a_last", int'(a_last), 0);
        chk_eq("rst_b_valid", int'(b_valid), 0);
        chk_eq("rst_b_busy", int'(b_busy), 0);
`ifdef PRIME_STREAM_COUNT_EN
        chk_eq("rst_a_count", int'(a_cnt), 0);
`endif
        reset = 1'b0;
        tick();

        // Test 1: full sieve, sink always ready, first-prime latency
        build_flags(0, 100, 1'b1, f);
        chk_eq("t1_expected_count", qa.size(), 25);
        base    = n_xfer_a;
        a_flags = f;
        a_done  = 1'b1;
        tick();                                   // E0 capture
        a_done  = 1'b0;
        chk_eq("t1_busy_after_capture", int'(a_busy), 1);
        tick();                                   // E1
        tick();                                   // E2
        chk_eq("t1_valid_after_e2", int'(a_valid), 0);
        tick();                                   // E3
        chk_eq("t1_valid_after_e3", int'(a_valid), 1);
        chk_eq("t1_prime_after_e3", int'(a_prime), 2);
        wait_drain_a();
        chk_eq("t1_all_sent_on_97", int'(a_all), 1);
        chk_eq("t1_xfers", n_xfer_a - base, 25);
        chk_eq("t1_valid_in_done", int'(a_valid), 0);
`ifdef PRIME_STREAM_COUNT_EN
        chk_eq("t1_count", int'(a_cnt), 25);
`endif

        // Test 2: backpressure while 3 is offered
        wait_idle_a();
        a_ready = 1'b0;
        build_flags(0, 100, 1'b1, f);
        a_flags = f;
        a_done  = 1'b1;
        tick();
        a_done  = 1'b0;
        wait_valid_a();
        chk_eq("t2_first_prime", int'(a_prime), 2);
        a_ready = 1'b1;
        tick();                                   // transfer of 2
        a_ready = 1'b0;
        tick();                                   // 3 offered
        for (int c = 0; c < 5; c++) begin
            chk_eq("t2_hold_valid", int'(a_valid), 1);
            chk_eq("t2_hold_prime", int'(a_prime), 3);
            chk_eq("t2_hold_last", int'(a_last), 0);
            tick();
        end
        a_ready = 1'b1;
        wait_drain_a();
        chk_eq("t2_all_sent", int'(a_all), 1);

        // Test 3: no primes at all
        wait_idle_a();
        a_vseen = 1'b0;
        a_flags = '1;
        a_done  = 1'b1;
        tick();                                   // E0 capture
        a_done  = 1'b0;
        n = 0;
        while (!a_all && n < 300) begin
            tick();
            n++;
        end
        chk_eq("t3_edges_to_done", n, 101);
        chk_eq("t3_no_valid", int'(a_vseen), 0);

        // Test 4: 7-index instance, flags 0101_0011
        qb.push_back(2);
        qb.push_back(3);
        qb.push_back(5);
        qb.push_back(7);
        b_flags = 8'b0101_0011;
        b_done  = 1'b1;
        tick();
        b_done  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (qb.size() == 0) break;
            tick();
        end
        chk_eq("t4_queue_drained", qb.size(), 0);
        chk_eq("t4_all_sent_on_7", int'(b_all), 1);
        chk_eq("t4_busy", int'(b_busy), 0);

        // Test 5: sieve_done held high through DONE, then re-armed
        wait_idle_a();
        build_flags(0, 13, 1'b1, f);
        a_flags = f;
        a_done  = 1'b1;
        tick();
        wait_drain_a();
        chk_eq("t5_first_all_sent", int'(a_all), 1);
        build_flags(50, 100, 1'b0, f);
        a_flags = f;
        repeat (5) tick();
        chk_eq("t5_no_recapture_all", int'(a_all), 1);
        chk_eq("t5_no_recapture_busy", int'(a_busy), 0);
        a_done = 1'b0;
        wait_idle_a();
        build_flags(50, 100, 1'b1, f);
        a_flags = f;
        a_done  = 1'b1;
        tick();
        a_done  = 1'b0;
        wait_drain_a();
        chk_eq("t5_second_all_sent", int'(a_all), 1);

        // Test 6: reset while 11 is offered, then a fresh full stream
        wait_idle_a();
        a_ready = 1'b0;
        build_flags(0, 100, 1'b1, f);
        a_flags = f;
        a_done  = 1'b1;
        tick();
        a_done  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_valid_a();
            if (a_prime == 7'd11) break;
            a_ready = 1'b1;
            tick();
            a_ready = 1'b0;
        end
        chk_eq("t6_at_11", int'(a_prime), 11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        qa.delete();
        chk_eq("t6_rst_valid", int'(a_valid), 0);
        chk_eq("t6_rst_prime", int'(a_prime), 0);
        chk_eq("t6_rst_last", int'(a_last), 0);
        chk_eq("t6_rst_all", int'(a_all), 0);
        chk_eq("t6_rst_busy", int'(a_busy), 0);
        a_ready = 1'b1;
        build_flags(0, 100, 1'b1, f);
        base    = n_xfer_a;
        a_flags = f;
        a_done  = 1'b1;
        tick();
        a_done  = 1'b0;
        wait_drain_a();
        chk_eq("t6_rerun_all", int'(a_all), 1);
        chk_eq("t6_rerun_xfers", n_xfer_a - base, 25);
`ifdef PRIME_STREAM_COUNT_EN
        chk_eq("t6_rerun_count", int'(a_cnt), 25);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
